voice_allocator: RTL and testbench
==================================

# voice_allocator

Assigns incoming note-on/note-off requests to the five square-wave voices that feed the 5-input voice summer. Holds per-voice active flag, note number and age; on note-on picks a retrigger, free or oldest voice (steal), on note-off releases matching voices. Sits between the note-request source and the voice oscillators; its `voice_en` bits gate the oscillator outputs entering the summer.

## Interface
- `NUM_VOICES`, 5, number of voice slots (summer width; fixed at 5 for this design)
- `NOTE_W`, 7, note number width
- `AGE_W`, 3, per-voice age counter width (saturating)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  allocator idle, can accept
- `req_on`  in  1  1 = note-on, 0 = note-off
- `req_note`  in  NOTE_W  note number (0 is a valid note)
- `panic`  in  1  synchronous all-voices-off
- `voice_en`  out  NUM_VOICES  bit i = voice i active
- `voice_note`  out  NUM_VOICES*NOTE_W  voice i note at bits [i*NOTE_W +: NOTE_W]
- `steal_pulse`  out  1  one-cycle pulse when a note-on stole an active voice

## Operation
- FSM states: IDLE, SCAN, COMMIT. `req_ready` = 1 only in IDLE and not `panic`.
- IDLE: on `req_valid && req_ready` latch `req_on`/`req_note`, clear scan index, go SCAN.
- SCAN: one voice per cycle, index 0..NUM_VOICES-1; after index NUM_VOICES-1 go COMMIT. Scan records: first voice with active && note == req_note (match), lowest-index inactive voice (free), active voice with max age, ties to lowest index (oldest).
- COMMIT, note-on, priority: match → retrigger that voice; else free → load note, set active; else oldest → overwrite note, assert `steal_pulse`. Chosen voice age := 0; every other active voice age := age+1, saturating at 2^AGE_W-1. Go IDLE.
- COMMIT, note-off: clear active on every voice whose note == latched note (all matches, not only first); ages unchanged; no match = no effect. Go IDLE.
- Inactive voices keep their last note; age of inactive voices is don't-care but reset to 0 when cleared.
- `panic`: overrides all, next edge clears all active and ages, state → IDLE, latched request discarded. Request presented with `panic` high is not accepted.
- Voice state changes only in COMMIT; scan results reflect a stable snapshot.

## Timing
- Reset values: `voice_en`=0, `voice_note`=0, ages 0, `steal_pulse`=0, state IDLE, so `req_ready`=1 after reset deassertion.
- Accept edge end of cycle T; SCAN cycles T+1..T+5; COMMIT T+6; new `voice_en`/`voice_note`/`steal_pulse` visible and `req_ready`=1 in T+7.
- Throughput: one request per 7 cycles; `req_ready` low T+1..T+6.
- `steal_pulse` high exactly cycle T+7, only for steals.
- `rst` mid-SCAN/COMMIT: immediate clear to reset values; in-flight request lost.
- All outputs registered; no combinational path from request inputs to voice outputs.

## Structure
- Package `voice_pkg`: `NUM_VOICES`, `NOTE_W`, `AGE_W`, FSM state enum (IDLE/SCAN/COMMIT), `AGE_MAX` constant.
- Sub-module `voice_slot`: per-voice active/note/age registers with load, clear, age-increment, age-zero controls; instantiated NUM_VOICES times. Scan/select and FSM stay in top.

## Test plan
- Reset then note-on 60 → T+7: `voice_en`=5'b00001, voice 0 note 60, `steal_pulse`=0, `req_ready`=1; `req_ready` low for 6 cycles.
- Note-on 60,62,64,65,67 → `voice_en`=5'b11111, notes in slots 0..4; sixth note-on 69 → slot 0 (oldest, age 4) gets 69, `steal_pulse` one cycle.
- Voices 60,62 active; note-on 60 → no new voice, slot 0 age 0, slot 1 age incremented; then note-off 60 → `voice_en`=5'b00010.
- Note-off 70 with no match → outputs unchanged; next request accepted at T+7.
- 9 note-ons on same 5 slots: ages saturate at 7, tie on steal picks lowest index.
- `panic` during SCAN of note-on 60 with 3 voices active → next cycle `voice_en`=0, IDLE, note 60 never allocated; async `rst` mid-SCAN gives same result immediately.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared constants and FSM state type for the voice allocator.
package voice_pkg;

    localparam int NUM_VOICES = 5;
    localparam int NOTE_W     = 7;
    localparam int AGE_W      = 3;
    localparam int IDX_W      = $clog2(NUM_VOICES);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice: active flag, note number and saturating age counter.
module voice_slot
    import voice_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              age_zero,
    input  logic              age_inc,
    input  logic [NOTE_W-1:0] note_in,
    output logic              active,
    output logic [NOTE_W-1:0] note,
    output logic [AGE_W-1:0]  age
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            note   <= '0;
            age    <= '0;
        end else if (clear) begin
            // Note is kept on release; only the flag and age are cleared.
            active <= 1'b0;
            age    <= '0;
        end else if (load) begin
            active <= 1'b1;
            note   <= note_in;
            age    <= '0;
        end else if (age_zero) begin
            age <= '0;
        end else if (age_inc && active && (age != AGE_MAX)) begin
            age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-on/off allocator: scans the voice slots one per cycle, then commits
// a retrigger, free-slot load, oldest-voice steal, or release.
module voice_allocator
    import voice_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_on,
    input  logic [NOTE_W-1:0]            req_note,
    input  logic                         panic,
    output logic [NUM_VOICES-1:0]        voice_en,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         steal_pulse
);

    state_t state, next_state;

    logic              accept, commit;
    logic [IDX_W-1:0]  idx;
    logic              lat_on;
    logic [NOTE_W-1:0] lat_note;

    logic              match_found, free_found, old_found;
    logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;

    logic              act   [NUM_VOICES];
    logic [NOTE_W-1:0] notes [NUM_VOICES];
    logic [AGE_W-1:0]  ages  [NUM_VOICES];

    logic [NUM_VOICES-1:0] slot_load, slot_clear, slot_age_zero, slot_age_inc;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_retrig;
    logic                  steal_now;

    logic              cur_act;
    logic [NOTE_W-1:0] cur_note;
    logic [AGE_W-1:0]  cur_age;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        if (panic) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        accept     = 1'b1;
                        next_state = SCAN;
                    end
                end
                SCAN: begin
                    if (idx == IDX_W'(NUM_VOICES - 1)) next_state = COMMIT;
                end
                COMMIT: begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE) && !panic;

    always_comb begin
        cur_act  = 1'b0;
        cur_note = '0;
        cur_age  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_act  = act[i];
                cur_note = notes[i];
                cur_age  = ages[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (accept) begin
            idx         <= '0;
            lat_on      <= req_on;
            lat_note    <= req_note;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
        end else if (state == SCAN && !panic) begin
            idx <= idx + 1'b1;
            if (cur_act && (cur_note == lat_note) && !match_found) begin
                match_found <= 1'b1;
                match_idx   <= idx;
            end
            if (!cur_act && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= idx;
            end
            // Strict greater-than keeps ties on the lowest index.
            if (cur_act && (!old_found || (cur_age > old_age))) begin
                old_found <= 1'b1;
                old_idx   <= idx;
                old_age   <= cur_age;
            end
        end
    end

    always_comb begin
        slot_load     = '0;
        slot_clear    = '0;
        slot_age_zero = '0;
        slot_age_inc  = '0;
        sel_idx       = '0;
        sel_retrig    = 1'b0;
        steal_now     = 1'b0;
        if (panic) begin
            slot_clear = '1;
        end else if (commit) begin
            if (lat_on) begin
                if (match_found) begin
                    sel_idx    = match_idx;
                    sel_retrig = 1'b1;
                end else if (free_found) begin
                    sel_idx = free_idx;
                end else begin
                    sel_idx   = old_idx;
                    steal_now = 1'b1;
                end
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    if (sel_idx == IDX_W'(i)) begin
                        slot_age_zero[i] = sel_retrig;
                        slot_load[i]     = !sel_retrig;
                    end else begin
                        slot_age_inc[i] = 1'b1;
                    end
                end
            end else begin
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    slot_clear[i] = act[i] && (notes[i] == lat_note);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) steal_pulse <= 1'b0;
        else     steal_pulse <= steal_now;
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_load[g]),
            .clear    (slot_clear[g]),
            .age_zero (slot_age_zero[g]),
            .age_inc  (slot_age_inc[g]),
            .note_in  (lat_note),
            .active   (act[g]),
            .note     (notes[g]),
            .age      (ages[g])
        );
        assign voice_en[g]                    = act[g];
        assign voice_note[g*NOTE_W +: NOTE_W] = notes[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_on;
    logic [6:0]  req_note;
    logic        panic;
    logic [4:0]  voice_en;
    logic [34:0] voice_note;
    logic        steal_pulse;

    int checks   = 0;
    int failures = 0;
    int busy;

    voice_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_on      (req_on),
        .req_note    (req_note),
        .panic       (panic),
        .voice_en    (voice_en),
        .voice_note  (voice_note),
        .steal_pulse (steal_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] vn(input int i);
        return voice_note[i*7 +: 7];
    endfunction

    task automatic do_reset();
        req_valid = 1'b0; req_on = 1'b0; req_note = '0; panic = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Presents one request; returns at cycle T+7 (+1) with the number of
    // sampled cycles after acceptance in which req_ready was low.
    task automatic send(input logic on, input logic [6:0] note, output int nbusy);
        @(negedge clk);
        req_on = on; req_note = note; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        nbusy = req_ready ? 0 : 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!req_ready) nbusy++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (voice_en !== 5'b0) begin failures++; $display("FAIL reset_en got=%b exp=%b", voice_en, 5'b0); end
        checks++; if (voice_note !== 35'b0) begin failures++; $display("FAIL reset_note got=%h exp=0", voice_note); end
        checks++; if (steal_pulse !== 1'b0) begin failures++; $display("FAIL reset_steal got=%b exp=0", steal_pulse); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        send(1'b1, 7'd60, busy);
        checks++; if (busy != 6) begin failures++; $display("FAIL single_busy got=%0d exp=6", busy); end
        checks++; if (voice_en !== 5'b00001) begin failures++; $display("FAIL single_en got=%b exp=00001", voice_en); end
        checks++; if (vn(0) !== 7'd60) begin failures++; $display("FAIL single_note got=%0d exp=60", vn(0)); end
        checks++; if (steal_pulse !== 1'b0) begin failures++; $display("FAIL single_steal got=%b exp=0", steal_pulse); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_fill_steal();
        do_reset();
        send(1'b1, 7'd60, busy);
        send(1'b1, 7'd62, busy);
        send(1'b1, 7'd64, busy);
        send(1'b1, 7'd65, busy);
        send(1'b1, 7'd67, busy);
        checks++; if (voice_en !== 5'b11111) begin failures++; $display("FAIL fill_en got=%b exp=11111", voice_en); end
        checks++; if (voice_note !== {7'd67, 7'd65, 7'd64, 7'd62, 7'd60}) begin failures++; $display("FAIL fill_notes got=%h exp=%h", voice_note, {7'd67, 7'd65, 7'd64, 7'd62, 7'd60}); end
        checks++; if (steal_pulse !== 1'b0) begin failures++; $display("FAIL fill_nosteal got=%b exp=0", steal_pulse); end
        send(1'b1, 7'd69, busy);
        checks++; if (voice_note !== {7'd67, 7'd65, 7'd64, 7'd62, 7'd69}) begin failures++; $display("FAIL steal_notes got=%h exp=%h", voice_note, {7'd67, 7'd65, 7'd64, 7'd62, 7'd69}); end
        checks++; if (steal_pulse !== 1'b1) begin failures++; $display("FAIL steal_pulse got=%b exp=1", steal_pulse); end
        checks++; if (voice_en !== 5'b11111) begin failures++; $display("FAIL steal_en got=%b exp=11111", voice_en); end
        @(posedge clk); #1;
        checks++; if (steal_pulse !== 1'b0) begin failures++; $display("FAIL steal_width got=%b exp=0", steal_pulse); end
    endtask

    task automatic test_retrigger_off();
        do_reset();
        send(1'b1, 7'd60, busy);
        send(1'b1, 7'd62, busy);
        send(1'b1, 7'd60, busy);
        checks++; if (voice_en !== 5'b00011) begin failures++; $display("FAIL retrig_en got=%b exp=00011", voice_en); end
        checks++; if (vn(0) !== 7'd60 || vn(1) !== 7'd62) begin failures++; $display("FAIL retrig_notes got=%0d,%0d exp=60,62", vn(0), vn(1)); end
        checks++; if (steal_pulse !== 1'b0) begin failures++; $display("FAIL retrig_steal got=%b exp=0", steal_pulse); end
        send(1'b0, 7'd60, busy);
        checks++; if (voice_en !== 5'b00010) begin failures++; $display("FAIL off_en got=%b exp=00010", voice_en); end
        checks++; if (vn(0) !== 7'd60) begin failures++; $display("FAIL off_keep_note got=%0d exp=60", vn(0)); end
        send(1'b1, 7'd64, busy);
        checks++; if (voice_en !== 5'b00011 || vn(0) !== 7'd64) begin failures++; $display("FAIL reuse_free got=%b/%0d exp=00011/64", voice_en, vn(0)); end
    endtask

    task automatic test_off_nomatch();
        send(1'b0, 7'd70, busy);
        checks++; if (busy != 6) begin failures++; $display("FAIL nomatch_busy got=%0d exp=6", busy); end
        checks++; if (voice_en !== 5'b00011) begin failures++; $display("FAIL nomatch_en got=%b exp=00011", voice_en); end
        checks++; if (vn(0) !== 7'd64 || vn(1) !== 7'd62) begin failures++; $display("FAIL nomatch_notes got=%0d,%0d exp=64,62", vn(0), vn(1)); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL nomatch_ready got=%b exp=1", req_ready); end
        send(1'b1, 7'd70, busy);
        checks++; if (busy != 6) begin failures++; $display("FAIL back_to_back_busy got=%0d exp=6", busy); end
        checks++; if (voice_en !== 5'b00111 || vn(2) !== 7'd70) begin failures++; $display("FAIL back_to_back got=%b/%0d exp=00111/70", voice_en, vn(2)); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 10; n < 15; n++) send(1'b1, 7'(n), busy);
        // Ages now 4,3,2,1,0; four retriggers of slot 4 push slot 0 past 7.
        repeat (4) send(1'b1, 7'd14, busy);
        send(1'b1, 7'd20, busy);
        checks++; if (vn(0) !== 7'd20 || vn(1) !== 7'd11) begin failures++; $display("FAIL sat_steal got=%0d,%0d exp=20,11", vn(0), vn(1)); end
        checks++; if (steal_pulse !== 1'b1) begin failures++; $display("FAIL sat_pulse got=%b exp=1", steal_pulse); end
        send(1'b1, 7'd21, busy);
        checks++; if (vn(1) !== 7'd21 || vn(2) !== 7'd12) begin failures++; $display("FAIL sat_tie got=%0d,%0d exp=21,12", vn(1), vn(2)); end
        checks++; if (vn(4) !== 7'd14 || voice_en !== 5'b11111) begin failures++; $display("FAIL sat_keep got=%0d/%b exp=14/11111", vn(4), voice_en); end
    endtask

    task automatic test_panic();
        do_reset();
        send(1'b1, 7'd1, busy);
        send(1'b1, 7'd2, busy);
        send(1'b1, 7'd3, busy);
        @(negedge clk);
        req_on = 1'b1; req_note = 7'd60; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        panic = 1'b1;
        @(posedge clk); #1;
        checks++; if (voice_en !== 5'b0) begin failures++; $display("FAIL panic_en got=%b exp=00000", voice_en); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL panic_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        req_valid = 1'b1; req_note = 7'd61;
        @(posedge clk);
        @(negedge clk);
        panic = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL panic_no_accept got=%b exp=1", req_ready); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (voice_en !== 5'b0) begin failures++; $display("FAIL panic_lost got=%b exp=00000", voice_en); end
        send(1'b1, 7'd5, busy);
        checks++; if (voice_en !== 5'b00001 || vn(0) !== 7'd5) begin failures++; $display("FAIL after_panic got=%b/%0d exp=00001/5", voice_en, vn(0)); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send(1'b1, 7'd1, busy);
        send(1'b1, 7'd2, busy);
        send(1'b1, 7'd3, busy);
        @(negedge clk);
        req_on = 1'b1; req_note = 7'd60; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (voice_en !== 5'b0 || voice_note !== 35'b0) begin failures++; $display("FAIL rst_mid got=%b/%h exp=00000/0", voice_en, voice_note); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (voice_en !== 5'b0) begin failures++; $display("FAIL rst_mid_lost got=%b exp=00000", voice_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_steal();
        test_retrigger_off();
        test_off_nomatch();
        test_saturate();
        test_panic();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
